// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared widths, writeback entry type and hold-buffer states
package rv32_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-load bits with set-wins update and hazard lookup
module rf_scoreboard
  import rv32_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              hazard_out
);
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear is applied before set so a same-cycle reissue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (set_en) pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hazard_out = pending_q[rs1] | pending_q[rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges execute and LSU writebacks onto the register file write port
module rf_wb_arbiter
  import rv32_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              exe_valid,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic [XLEN-1:0]   exe_data,
  output logic              exe_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic              iss_ld_valid,
  input  logic [REG_AW-1:0] iss_ld_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  output logic              hazard_out,
  output logic              wr_en_out,
  output logic [REG_AW-1:0] wr_addr_out,
  output logic [XLEN-1:0]   wr_data_out
);
  hold_state_t       state_q, state_d;
  wb_entry_t         hold_q, hold_d;
  wb_entry_t         grant;
  logic              lsu_grant;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    grant     = '0;
    lsu_grant = 1'b0;
    exe_ready = !rst_in && (state_q == HOLD_EMPTY);
    lsu_ready = !rst_in && (state_q == HOLD_EMPTY);
    case (state_q)
      HOLD_FULL: begin
        grant   = hold_q;
        state_d = HOLD_EMPTY;
      end
      default: begin
        // LSU outranks a direct execute result; the loser parks in the buffer.
        if (lsu_valid) begin
          grant     = '{valid: 1'b1, rd: lsu_rd, data: lsu_data};
          lsu_grant = 1'b1;
          if (exe_valid) begin
            hold_d  = '{valid: 1'b1, rd: exe_rd, data: exe_data};
            state_d = HOLD_FULL;
          end
        end else if (exe_valid) begin
          grant = '{valid: 1'b1, rd: exe_rd, data: exe_data};
        end
      end
    endcase
    // x0 still consumes the slot but never raises the write enable.
    wr_en_d   = grant.valid && (grant.rd != '0);
    wr_addr_d = grant.valid ? grant.rd   : wr_addr_q;
    wr_data_d = grant.valid ? grant.data : wr_data_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= HOLD_EMPTY;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;

  rf_scoreboard u_scoreboard (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .set_en     (iss_ld_valid),
    .set_rd     (iss_ld_rd),
    .clr_en     (lsu_grant),
    .clr_rd     (lsu_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .hazard_out (hazard_out)
  );
endmodule
